ram_bist_ctrl: RTL and testbench

Parametrised write/read-verify engine around an internally inferred simple dual-port RAM, with one write port and one read port on the same clock. A run fills every address with a selectable data pattern, reads the RAM back, compares each word against the regenerated pattern, and reports error count, first failing address/data and pass status. Optional looping repeats runs back-to-back. The write and read ports are exported for debug probing, and a fault-injection input lets a bench prove that the checker detects mismatches.

---
 rtl/ram_bist_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// Fills an inferred simple dual-port RAM with a pattern, reads it back and checks every word.
// Latency: start edge to done cycle is 2*DEPTH+2 cycles; no backpressure, runs to completion once started.
module ram_bist_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int ERR_W  = 16
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  input  logic              loop,
  input  logic              inj_en,
  input  logic [ADDR_W-1:0] inj_addr,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_cnt,
  output logic [ERR_W-1:0]  pass_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data,
  output logic              ram_wr_en,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output logic [DATA_W-1:0] ram_wr_data,
  output logic              ram_rd_en,
  output logic [ADDR_W-1:0] ram_rd_addr,
  output logic [DATA_W-1:0] ram_rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t state, state_nxt;

  logic [1:0]        mode_q, mode_nxt;
  logic [DATA_W-1:0] seed_q, seed_nxt;
  logic              inj_en_q, inj_en_nxt;
  logic [ADDR_W-1:0] inj_addr_q, inj_addr_nxt;

  logic              launch;
  logic              new_run;
  logic [ADDR_W-1:0] wr_addr_nxt;
  logic [DATA_W-1:0] wr_data_nxt;
  logic [DATA_W-1:0] exp_dat;
  logic              mismatch;

  logic              cmp_vld;
  logic [ADDR_W-1:0] cmp_addr;
  logic              run_err;
  logic              err_seen;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [DATA_W-1:0] pattern(input logic [ADDR_W-1:0] a,
                                                 input logic [1:0]        m,
                                                 input logic [DATA_W-1:0] s);
    logic [DATA_W+ADDR_W-1:0] sum;
    logic [DATA_W-1:0]        one;
    int                       sh;
    sum = {{ADDR_W{1'b0}}, s} + {{DATA_W{1'b0}}, a};
    one = {{(DATA_W-1){1'b0}}, 1'b1};
    sh  = int'(a) % DATA_W;
    case (m)
      2'd0:    pattern = sum[DATA_W-1:0];
      2'd1:    pattern = s;
      2'd2:    pattern = a[0] ? ~s : s;
      default: pattern = one << sh;
    endcase
  endfunction

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    case (state)
      S_IDLE:  if (start) begin
                 state_nxt = S_WRITE;
                 launch    = 1'b1;
               end
      S_WRITE: if (ram_wr_addr == '1) state_nxt = S_READ;
      S_READ:  if (ram_rd_addr == '1) state_nxt = S_DRAIN;
      S_DRAIN: state_nxt = S_DONE;
      S_DONE:  state_nxt = loop ? S_WRITE : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase

    new_run      = (state_nxt == S_WRITE) && (state != S_WRITE);
    // The word written on the launch edge must already use the incoming settings.
    mode_nxt     = launch ? mode     : mode_q;
    seed_nxt     = launch ? seed     : seed_q;
    inj_en_nxt   = launch ? inj_en   : inj_en_q;
    inj_addr_nxt = launch ? inj_addr : inj_addr_q;

    wr_addr_nxt = (state == S_WRITE) ? ram_wr_addr + ADDR_W'(1) : '0;
    wr_data_nxt = pattern(wr_addr_nxt, mode_nxt, seed_nxt) ^
                  {{(DATA_W-1){1'b0}}, (inj_en_nxt && (wr_addr_nxt == inj_addr_nxt))};

    exp_dat  = pattern(cmp_addr, mode_q, seed_q);
    mismatch = cmp_vld && (ram_rd_data != exp_dat);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_cnt        <= '0;
      pass_cnt       <= '0;
      first_err_addr <= '0;
      first_err_data <= '0;
      ram_wr_en      <= 1'b0;
      ram_wr_addr    <= '0;
      ram_wr_data    <= '0;
      ram_rd_en      <= 1'b0;
      ram_rd_addr    <= '0;
      mode_q         <= '0;
      seed_q         <= '0;
      inj_en_q       <= 1'b0;
      inj_addr_q     <= '0;
      cmp_vld        <= 1'b0;
      cmp_addr       <= '0;
      run_err        <= 1'b0;
      err_seen       <= 1'b0;
    end else begin
      busy      <= (state_nxt == S_WRITE) || (state_nxt == S_READ) || (state_nxt == S_DRAIN);
      done      <= (state_nxt == S_DONE);
      ram_wr_en <= (state_nxt == S_WRITE);
      ram_rd_en <= (state_nxt == S_READ);

      mode_q     <= mode_nxt;
      seed_q     <= seed_nxt;
      inj_en_q   <= inj_en_nxt;
      inj_addr_q <= inj_addr_nxt;

      if (state_nxt == S_WRITE) begin
        ram_wr_addr <= wr_addr_nxt;
        ram_wr_data <= wr_data_nxt;
      end
      if (state_nxt == S_READ)
        ram_rd_addr <= (state == S_READ) ? ram_rd_addr + ADDR_W'(1) : '0;

      // Read data lands one cycle after the address, so the compare tracks a delayed copy.
      cmp_vld  <= ram_rd_en;
      cmp_addr <= ram_rd_addr;

      if (launch) begin
        err_cnt        <= '0;
        pass_cnt       <= '0;
        first_err_addr <= '0;
        first_err_data <= '0;
        err_seen       <= 1'b0;
      end else begin
        if (mismatch) begin
          if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
          if (!err_seen) begin
            err_seen       <= 1'b1;
            first_err_addr <= cmp_addr;
            first_err_data <= ram_rd_data;
          end
        end
        if (state_nxt == S_DONE) pass_cnt <= pass_cnt + ERR_W'(1);
      end

      if (new_run)       run_err <= 1'b0;
      else if (mismatch) run_err <= 1'b1;

      if (state_nxt == S_DONE) pass <= !(run_err || mismatch);
    end
  end

  // Storage is deliberately reset-free so a reset does not disturb RAM contents.
  always_ff @(posedge sys_clk) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_rd_addr];
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Scoreboard bench for ram_bist_ctrl: write-tap words and per-run results are queued at start
// and compared when the DUT writes a word or pulses done.
module tb_ram_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Default-parameter instance
  logic        start = 0, loop = 0, inj_en = 0;
  logic [1:0]  mode = 0;
  logic [7:0]  seed = 0;
  logic [5:0]  inj_addr = 0;
  logic        busy, done, pass, wr_en, rd_en;
  logic [15:0] err_cnt, pass_cnt;
  logic [5:0]  fe_addr, wr_addr, rd_addr;
  logic [7:0]  fe_data, wr_data, rd_data;

  ram_bist_ctrl u_dut (
    .sys_clk(clk), .sys_rst(rst), .start(start), .mode(mode), .seed(seed), .loop(loop),
    .inj_en(inj_en), .inj_addr(inj_addr), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .pass_cnt(pass_cnt), .first_err_addr(fe_addr), .first_err_data(fe_data),
    .ram_wr_en(wr_en), .ram_wr_addr(wr_addr), .ram_wr_data(wr_data),
    .ram_rd_en(rd_en), .ram_rd_addr(rd_addr), .ram_rd_data(rd_data)
  );

  // Wide-word, shallow instance
  logic        start_b = 0;
  logic [1:0]  mode_b = 0;
  logic [15:0] seed_b = 0;
  logic        busy_b, done_b, pass_b, wr_en_b, rd_en_b;
  logic [15:0] err_cnt_b, pass_cnt_b;
  logic [3:0]  fe_addr_b, wr_addr_b, rd_addr_b;
  logic [15:0] fe_data_b, wr_data_b, rd_data_b;

  ram_bist_ctrl #(.DATA_W(16), .ADDR_W(4), .ERR_W(16)) u_dut_b (
    .sys_clk(clk), .sys_rst(rst), .start(start_b), .mode(mode_b), .seed(seed_b), .loop(1'b0),
    .inj_en(1'b0), .inj_addr(4'd0), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_cnt(err_cnt_b), .pass_cnt(pass_cnt_b), .first_err_addr(fe_addr_b),
    .first_err_data(fe_data_b), .ram_wr_en(wr_en_b), .ram_wr_addr(wr_addr_b),
    .ram_wr_data(wr_data_b), .ram_rd_en(rd_en_b), .ram_rd_addr(rd_addr_b),
    .ram_rd_data(rd_data_b)
  );

  typedef struct { int pass; int err; int pcnt; int fa; int fd; int due; } res_t;
  typedef struct { int a; int d; } wr_t;

  res_t res_q[$];
  wr_t  wr_q[$];
  res_t res_b_q[$];
  wr_t  wr_b_q[$];

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int pat(input int a, input int m, input int s, input int dw);
    int mask;
    mask = (1 << dw) - 1;
    case (m)
      0:       return (s + a) & mask;
      1:       return s & mask;
      2:       return ((a & 1) != 0) ? (~s & mask) : (s & mask);
      default: return (1 << (a % dw)) & mask;
    endcase
  endfunction

  task automatic issue_a(input int m, input int s, input int ie, input int ia, input int nruns);
    for (int r = 0; r < nruns; r++) begin
      for (int a = 0; a < 64; a++) begin
        int d;
        d = pat(a, m, s, 8);
        if (ie != 0 && a == ia) d = d ^ 1;
        wr_q.push_back('{a, d});
      end
      res_q.push_back('{(ie == 0) ? 1 : 0, (ie != 0) ? r + 1 : 0, r + 1,
                        (ie != 0) ? ia : 0, (ie != 0) ? (pat(ia, m, s, 8) ^ 1) : 0,
                        cyc + 130 * (r + 1)});
    end
    mode = 2'(m); seed = 8'(s); inj_en = (ie != 0); inj_addr = 6'(ia);
    loop = (nruns > 1); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_a(input int limit);
    for (int i = 0; i < limit && res_q.size() != 0; i++) begin
      @(posedge clk); #1;
      if (res_q.size() == 1) loop = 1'b0;
    end
    if (res_q.size() != 0) begin
      check_val("run_timeout", res_q.size(), 0);
      res_q.delete(); wr_q.delete();
    end
    loop = 1'b0;
  endtask

  task automatic issue_b(input int m, input int s);
    for (int a = 0; a < 16; a++) wr_b_q.push_back('{a, pat(a, m, s, 16)});
    res_b_q.push_back('{1, 0, 1, 0, 0, cyc + 34});
    mode_b = 2'(m); seed_b = 16'(s); start_b = 1'b1;
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_b(input int limit);
    for (int i = 0; i < limit && res_b_q.size() != 0; i++) begin
      @(posedge clk); #1;
    end
    if (res_b_q.size() != 0) begin
      check_val("run_b_timeout", res_b_q.size(), 0);
      res_b_q.delete(); wr_b_q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (wr_en) begin
        if (wr_q.size() == 0) check_val("wr_unexpected", 1, 0);
        else begin
          wr_t e;
          e = wr_q.pop_front();
          check_val("wr_addr", wr_addr, e.a);
          check_val("wr_data", wr_data, e.d);
        end
      end
      if (done) begin
        if (res_q.size() == 0) check_val("done_unexpected", 1, 0);
        else begin
          res_t e;
          e = res_q.pop_front();
          check_val("done_cycle", cyc, e.due);
          check_val("pass", pass, e.pass);
          check_val("err_cnt", err_cnt, e.err);
          check_val("pass_cnt", pass_cnt, e.pcnt);
          check_val("first_err_addr", fe_addr, e.fa);
          check_val("first_err_data", fe_data, e.fd);
        end
      end
      if (wr_en_b) begin
        if (wr_b_q.size() == 0) check_val("wr_b_unexpected", 1, 0);
        else begin
          wr_t e;
          e = wr_b_q.pop_front();
          check_val("wr_b_addr", wr_addr_b, e.a);
          check_val("wr_b_data", wr_data_b, e.d);
        end
      end
      if (done_b) begin
        if (res_b_q.size() == 0) check_val("done_b_unexpected", 1, 0);
        else begin
          res_t e;
          e = res_b_q.pop_front();
          check_val("done_b_cycle", cyc, e.due);
          check_val("pass_b", pass_b, e.pass);
          check_val("err_cnt_b", err_cnt_b, e.err);
          check_val("pass_cnt_b", pass_cnt_b, e.pcnt);
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check_val({tag, "_busy"}, busy, 0);
    check_val({tag, "_done"}, done, 0);
    check_val({tag, "_pass"}, pass, 0);
    check_val({tag, "_err_cnt"}, err_cnt, 0);
    check_val({tag, "_pass_cnt"}, pass_cnt, 0);
    check_val({tag, "_fe_addr"}, fe_addr, 0);
    check_val({tag, "_fe_data"}, fe_data, 0);
    check_val({tag, "_wr_en"}, wr_en, 0);
    check_val({tag, "_rd_en"}, rd_en, 0);
    check_val({tag, "_wr_addr"}, wr_addr, 0);
    check_val({tag, "_rd_addr"}, rd_addr, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    check_val("reset_busy_b", busy_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Incrementing pattern, clean run; write tap holds the last word afterwards
    issue_a(0, 'h10, 0, 0, 1);
    wait_a(400);
    check_val("idle_busy", busy, 0);
    check_val("idle_done", done, 0);
    check_val("last_wr_addr", wr_addr, 63);
    check_val("last_wr_data", wr_data, 'h4F);

    // Checkerboard with one injected fault
    issue_a(2, 'hA5, 1, 17, 1);
    wait_a(400);

    // Walking one, three looped runs, fault at address 9
    issue_a(3, 'h5C, 1, 9, 3);
    wait_a(1000);

    // A start pulse during READ with different settings must be ignored
    issue_a(1, 'h3C, 0, 0, 1);
    repeat (90) @(posedge clk);
    #1;
    check_val("mid_busy", busy, 1);
    check_val("mid_rd_en", rd_en, 1);
    mode = 2'd0; seed = 8'h00; inj_en = 1'b1; inj_addr = 6'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_a(400);
    repeat (5) @(posedge clk);
    #1;
    check_val("post_ignore_busy", busy, 0);

    // Reset mid-WRITE, then a clean run
    issue_a(0, 'h77, 0, 0, 1);
    repeat (20) @(posedge clk);
    #1;
    check_val("pre_rst_wr_en", wr_en, 1);
    rst = 1'b1;
    res_q.delete(); wr_q.delete();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("post_rst_idle", busy, 0);
    issue_a(0, 'h77, 0, 0, 1);
    wait_a(400);

    // Wide word, shallow RAM: incrementing pattern wraps past all-ones
    issue_b(0, 'hFFFE);
    wait_b(200);

    repeat (4) @(posedge clk);
    check_val("scoreboard_empty", res_q.size() + wr_q.size() + res_b_q.size() + wr_b_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
